// File: rtl/punc_datapath_p.sv
// Datapath for a small LC-3-style machine: PC, IR, condition codes and a
// register file, driven by a one-command-at-a-time handshake and a simple memory port.
module punc_datapath_p #(
    parameter int unsigned      WIDTH    = 16,
    parameter int unsigned      NREGS    = 8,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    localparam int unsigned     RA_W     = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [RA_W-1:0]  cmd_rd,
    input  logic [RA_W-1:0]  cmd_sa,
    input  logic [RA_W-1:0]  cmd_sb,
    input  logic [1:0]       cmd_fn,
    input  logic             cmd_imm,
    input  logic             cmd_base,
    input  logic             cmd_link,
    output logic             cmd_done,
    output logic             cmd_err,
    output logic [WIDTH-1:0] ir,
    output logic [2:0]       nzp,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic [RA_W-1:0]  rf_debug_addr,
    output logic [WIDTH-1:0] rf_debug_data,
    output logic [WIDTH-1:0] pc_debug_data
);

    localparam logic [2:0] OP_FETCH  = 3'd0;
    localparam logic [2:0] OP_ALU    = 3'd1;
    localparam logic [2:0] OP_LOAD   = 3'd2;
    localparam logic [2:0] OP_STORE  = 3'd3;
    localparam logic [2:0] OP_BRANCH = 3'd4;
    localparam logic [2:0] OP_JUMP   = 3'd5;
    localparam logic [2:0] OP_LEA    = 3'd6;

    localparam logic [1:0] FN_ADD = 2'd0;
    localparam logic [1:0] FN_AND = 2'd1;
    localparam logic [1:0] FN_NOT = 2'd2;

    localparam logic [RA_W-1:0] LINK_REG = RA_W'(7);

    typedef enum logic [1:0] {S_IDLE, S_MEM, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  pc_q, pc_d;
    logic [WIDTH-1:0]  ir_q, ir_d;
    logic [2:0]        nzp_q, nzp_d;
    logic [WIDTH-1:0]  rf_q [NREGS];
    logic [WIDTH-1:0]  rf_d [NREGS];
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic [2:0]        mem_op_q, mem_op_d;
    logic [RA_W-1:0]   mem_rd_q, mem_rd_d;
    logic              cmd_done_q, cmd_done_d;
    logic              cmd_err_q, cmd_err_d;

    logic              rf_we;
    logic [RA_W-1:0]   rf_wa;
    logic [WIDTH-1:0]  rf_wd;
    logic [WIDTH-1:0]  rf_a, rf_b, alu_b, alu_res, ls_addr;
    logic [WIDTH-1:0]  imm5, off6, off9, off11;
    logic              br_taken;

    function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1])   return 3'b100;
        else if (v == '0) return 3'b010;
        else              return 3'b001;
    endfunction

    // Sign-extended IR fields
    assign imm5  = {{(WIDTH-5){ir_q[4]}},   ir_q[4:0]};
    assign off6  = {{(WIDTH-6){ir_q[5]}},   ir_q[5:0]};
    assign off9  = {{(WIDTH-9){ir_q[8]}},   ir_q[8:0]};
    assign off11 = {{(WIDTH-11){ir_q[10]}}, ir_q[10:0]};

    // Operand fetch and ALU
    always_comb begin
        rf_a  = rf_q[cmd_sa];
        rf_b  = rf_q[cmd_sb];
        alu_b = cmd_imm ? imm5 : rf_b;
        case (cmd_fn)
            FN_ADD:  alu_res = rf_a + alu_b;
            FN_AND:  alu_res = rf_a & alu_b;
            FN_NOT:  alu_res = ~rf_a;
            default: alu_res = rf_a;
        endcase
        ls_addr  = cmd_base ? (rf_a + off6) : (pc_q + off9);
        br_taken = |(ir_q[11:9] & nzp_q);
    end

    // Next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        nzp_d       = nzp_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_op_d    = mem_op_q;
        mem_rd_d    = mem_rd_q;
        cmd_done_d  = 1'b0;
        cmd_err_d   = 1'b0;
        rf_we       = 1'b0;
        rf_wa       = cmd_rd;
        rf_wd       = alu_res;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    mem_op_d   = cmd_op;
                    mem_rd_d   = cmd_rd;
                    state_d    = S_DONE;
                    cmd_done_d = 1'b1;
                    case (cmd_op)
                        OP_FETCH: begin
                            state_d    = S_MEM;
                            cmd_done_d = 1'b0;
                            mem_req_d  = 1'b1;
                            mem_we_d   = 1'b0;
                            mem_addr_d = pc_q;
                        end
                        OP_LOAD: begin
                            state_d    = S_MEM;
                            cmd_done_d = 1'b0;
                            mem_req_d  = 1'b1;
                            mem_we_d   = 1'b0;
                            mem_addr_d = ls_addr;
                        end
                        OP_STORE: begin
                            state_d     = S_MEM;
                            cmd_done_d  = 1'b0;
                            mem_req_d   = 1'b1;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = ls_addr;
                            mem_wdata_d = rf_b;
                        end
                        OP_ALU: begin
                            rf_we = 1'b1;
                            rf_wd = alu_res;
                            nzp_d = nzp_of(alu_res);
                        end
                        OP_BRANCH: begin
                            if (br_taken) pc_d = pc_q + off9;
                        end
                        OP_JUMP: begin
                            // Target uses rf_a read before the link write lands
                            pc_d = cmd_base ? rf_a : (pc_q + off11);
                            if (cmd_link) begin
                                rf_we = 1'b1;
                                rf_wa = LINK_REG;
                                rf_wd = pc_q;
                            end
                        end
                        OP_LEA: begin
                            rf_we = 1'b1;
                            rf_wd = pc_q + off9;
                        end
                        default: cmd_err_d = 1'b1;
                    endcase
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    state_d    = S_DONE;
                    cmd_done_d = 1'b1;
                    if (mem_op_q == OP_FETCH) begin
                        ir_d = mem_rdata;
                        pc_d = pc_q + WIDTH'(1);
                    end else if (mem_op_q == OP_LOAD) begin
                        rf_we = 1'b1;
                        rf_wa = mem_rd_q;
                        rf_wd = mem_rdata;
                        nzp_d = nzp_of(mem_rdata);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        rf_d = rf_q;
        if (rf_we) rf_d[rf_wa] = rf_wd;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            nzp_q       <= 3'b010;
            rf_q        <= '{default: '0};
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_op_q    <= '0;
            mem_rd_q    <= '0;
            cmd_done_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            nzp_q       <= nzp_d;
            rf_q        <= rf_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_op_q    <= mem_op_d;
            mem_rd_q    <= mem_rd_d;
            cmd_done_q  <= cmd_done_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    // Ready is held low while reset is asserted even though the FSM sits in IDLE
    assign cmd_ready     = (state_q == S_IDLE) && rst;
    assign cmd_done      = cmd_done_q;
    assign cmd_err       = cmd_err_q;
    assign ir            = ir_q;
    assign nzp           = nzp_q;
    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign rf_debug_data = rf_q[rf_debug_addr];
    assign pc_debug_data = pc_q;

endmodule

// File: tb/tb_punc_datapath_p.sv
// Bench for punc_datapath_p: directed scenarios plus random commands
// checked against an arithmetic model of the architectural state.
module tb_punc_datapath_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        cmd_valid, cmd_ready, cmd_imm, cmd_base, cmd_link, cmd_done, cmd_err;
    logic [2:0]  cmd_op, cmd_rd, cmd_sa, cmd_sb, nzp, rf_debug_addr;
    logic [1:0]  cmd_fn;
    logic [15:0] ir, mem_addr, mem_wdata, mem_rdata, rf_debug_data, pc_debug_data;
    logic        mem_req, mem_we, mem_ack;

    logic        w_cmd_valid, w_cmd_ready, w_cmd_done, w_cmd_err, w_mem_req, w_mem_we, w_mem_ack;
    logic [2:0]  w_cmd_op, w_nzp;
    logic [3:0]  w_rf_debug_addr;
    logic [31:0] w_ir, w_mem_addr, w_mem_wdata, w_mem_rdata, w_rf_debug_data, w_pc_debug_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] m_pc, m_ir;
    logic [2:0]  m_nzp;
    logic [15:0] m_rf [8];

    punc_datapath_p dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_sa(cmd_sa), .cmd_sb(cmd_sb), .cmd_fn(cmd_fn), .cmd_imm(cmd_imm),
        .cmd_base(cmd_base), .cmd_link(cmd_link), .cmd_done(cmd_done), .cmd_err(cmd_err),
        .ir(ir), .nzp(nzp), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rf_debug_addr(rf_debug_addr), .rf_debug_data(rf_debug_data), .pc_debug_data(pc_debug_data)
    );

    punc_datapath_p #(.WIDTH(32), .NREGS(16), .RESET_PC(32'hFFFF_FFFF)) dut_w (
        .clk(clk), .rst(rst), .cmd_valid(w_cmd_valid), .cmd_ready(w_cmd_ready), .cmd_op(w_cmd_op),
        .cmd_rd(4'd0), .cmd_sa(4'd0), .cmd_sb(4'd0), .cmd_fn(2'd0), .cmd_imm(1'b0),
        .cmd_base(1'b0), .cmd_link(1'b0), .cmd_done(w_cmd_done), .cmd_err(w_cmd_err),
        .ir(w_ir), .nzp(w_nzp), .mem_req(w_mem_req), .mem_we(w_mem_we), .mem_addr(w_mem_addr),
        .mem_wdata(w_mem_wdata), .mem_ack(w_mem_ack), .mem_rdata(w_mem_rdata),
        .rf_debug_addr(w_rf_debug_addr), .rf_debug_data(w_rf_debug_data),
        .pc_debug_data(w_pc_debug_data)
    );

    // ---------------- reference model ----------------
    function automatic int sx(input logic [15:0] v, input int n);
        int f;
        f = int'(v) & ((1 << n) - 1);
        if (f >= (1 << (n - 1))) f = f - (1 << n);
        return f;
    endfunction

    function automatic logic [2:0] cc(input logic [15:0] v);
        if (v >= 16'h8000) return 3'b100;
        if (v == 16'h0000) return 3'b010;
        return 3'b001;
    endfunction

    task automatic model_reset();
        m_pc = 16'h0; m_ir = 16'h0; m_nzp = 3'b010;
        for (int r = 0; r < 8; r++) m_rf[r] = 16'h0;
    endtask

    task automatic model_step(input logic [2:0] op, rd, sa, sb, input logic [1:0] fn,
                              input logic imm, base, link, input logic [15:0] rdata,
                              output logic e_mem, output logic [15:0] e_addr,
                              output logic e_we, output logic [15:0] e_wdata, output logic e_err);
        logic [15:0] a, b, r, old_pc;
        e_mem = 1'b0; e_addr = 16'h0; e_we = 1'b0; e_wdata = 16'h0; e_err = 1'b0;
        case (op)
            3'd0: begin e_mem = 1'b1; e_addr = m_pc; m_ir = rdata; m_pc = 16'(int'(m_pc) + 1); end
            3'd1: begin
                a = m_rf[sa];
                b = imm ? 16'(sx(m_ir, 5)) : m_rf[sb];
                case (fn)
                    2'd0: r = 16'(int'(a) + int'(b));
                    2'd1: r = a & b;
                    2'd2: r = 16'hFFFF - a;
                    default: r = a;
                endcase
                m_rf[rd] = r; m_nzp = cc(r);
            end
            3'd2, 3'd3: begin
                e_mem  = 1'b1;
                e_addr = base ? 16'(int'(m_rf[sa]) + sx(m_ir, 6)) : 16'(int'(m_pc) + sx(m_ir, 9));
                if (op == 3'd3) begin e_we = 1'b1; e_wdata = m_rf[sb]; end
                else begin m_rf[rd] = rdata; m_nzp = cc(rdata); end
            end
            3'd4: if ((m_ir[11:9] & m_nzp) != 3'b000) m_pc = 16'(int'(m_pc) + sx(m_ir, 9));
            3'd5: begin
                old_pc = m_pc;
                m_pc = base ? m_rf[sa] : 16'(int'(old_pc) + sx(m_ir, 11));
                if (link) m_rf[7] = old_pc;
            end
            3'd6: m_rf[rd] = 16'(int'(m_pc) + sx(m_ir, 9));
            default: e_err = 1'b1;
        endcase
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; cmd_valid = 1'b0; mem_ack = 1'b0; w_cmd_valid = 1'b0; w_mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic issue(input logic [2:0] op, rd, sa, sb, input logic [1:0] fn,
                         input logic imm, base, link, input logic [15:0] rdata, input int waits,
                         output int lat, output logic err_o, output logic [15:0] o_addr,
                         output logic o_we, output logic [15:0] o_wdata, output logic o_stable,
                         output int req_n);
        int guard = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_sa = sa; cmd_sb = sb;
        cmd_fn = fn; cmd_imm = imm; cmd_base = base; cmd_link = link;
        while (!cmd_ready && guard < 20) begin @(negedge clk); guard++; end
        if (!cmd_ready) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 0; req_n = 0; o_stable = 1'b1;
        o_addr = mem_addr; o_we = mem_we; o_wdata = mem_wdata;
        while (!cmd_done && lat < 100) begin
            mem_ack = 1'b0;
            if (mem_req) begin
                if (req_n == 0) begin o_addr = mem_addr; o_we = mem_we; o_wdata = mem_wdata; end
                else if (mem_addr !== o_addr || mem_we !== o_we || mem_wdata !== o_wdata) o_stable = 1'b0;
                req_n++;
                if (req_n > waits) begin mem_ack = 1'b1; mem_rdata = rdata; end
            end
            @(negedge clk);
            lat++;
        end
        mem_ack = 1'b0;
        err_o = cmd_err;
        if (!cmd_done) begin
            n_cmp++; n_err++;
            $display("FAIL done_timeout: cmd_done=%b required 1", cmd_done);
        end
    endtask

    task automatic setr(input logic [2:0] rd, input logic [15:0] val);
        int l, q; logic e, we, st; logic [15:0] ad, wd;
        issue(3'd2, rd, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, val, 0, l, e, ad, we, wd, st, q);
    endtask

    task automatic setpc(input logic [15:0] val);
        int l, q; logic e, we, st; logic [15:0] ad, wd;
        setr(3'd6, val);
        issue(3'd5, 3'd0, 3'd6, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0, 0, l, e, ad, we, wd, st, q);
    endtask

    task automatic fetch(input logic [15:0] val);
        int l, q; logic e, we, st; logic [15:0] ad, wd;
        issue(3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, val, 0, l, e, ad, we, wd, st, q);
    endtask

    task automatic w_issue(input logic [2:0] op, input logic [31:0] rdata,
                           output int lat, output logic err_o);
        int guard = 0;
        @(negedge clk);
        w_cmd_valid = 1'b1; w_cmd_op = op;
        while (!w_cmd_ready && guard < 20) begin @(negedge clk); guard++; end
        @(negedge clk);
        w_cmd_valid = 1'b0; lat = 0;
        while (!w_cmd_done && lat < 50) begin
            w_mem_ack = w_mem_req; w_mem_rdata = rdata;
            @(negedge clk);
            lat++;
        end
        w_mem_ack = 1'b0;
        err_o = w_cmd_err;
        if (!w_cmd_done) begin
            n_cmp++; n_err++;
            $display("FAIL w_done_timeout: cmd_done=%b required 1", w_cmd_done);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", cmd_ready); end
        n_cmp++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem: req=%b we=%b want 0 0", mem_req, mem_we); end
        n_cmp++; if (cmd_done !== 1'b0 || cmd_err !== 1'b0) begin n_err++; $display("FAIL rst_done: done=%b err=%b want 0 0", cmd_done, cmd_err); end
        n_cmp++; if (pc_debug_data !== 16'h0) begin n_err++; $display("FAIL rst_pc: got %h want 0000", pc_debug_data); end
        n_cmp++; if (ir !== 16'h0) begin n_err++; $display("FAIL rst_ir: got %h want 0000", ir); end
        n_cmp++; if (nzp !== 3'b010) begin n_err++; $display("FAIL rst_nzp: got %b want 010", nzp); end
        n_cmp++; if (w_pc_debug_data !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rst_w_pc: got %h want ffffffff", w_pc_debug_data); end
        for (int r = 0; r < 8; r++) begin
            rf_debug_addr = 3'(r); #1;
            n_cmp++; if (rf_debug_data !== 16'h0) begin n_err++; $display("FAIL rst_rf%0d: got %h want 0000", r, rf_debug_data); end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_fetch();
        int lat, req_n; logic e, we, st; logic [15:0] ad, wd;
        issue(3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h1234, 3, lat, e, ad, we, wd, st, req_n);
        n_cmp++; if (req_n !== 4) begin n_err++; $display("FAIL fetch_req_cycles: got %0d want 4", req_n); end
        n_cmp++; if (ad !== 16'h0 || we !== 1'b0) begin n_err++; $display("FAIL fetch_addr: got %h we=%b want 0000 we=0", ad, we); end
        n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL fetch_stable: got %b want 1", st); end
        n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL fetch_done_lat: got %0d want 4", lat); end
        n_cmp++; if (ir !== 16'h1234) begin n_err++; $display("FAIL fetch_ir: got %h want 1234", ir); end
        n_cmp++; if (pc_debug_data !== 16'h0001) begin n_err++; $display("FAIL fetch_pc: got %h want 0001", pc_debug_data); end
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL fetch_req_drop: got %b want 0", mem_req); end
        @(negedge clk);
        n_cmp++; if (cmd_done !== 1'b0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL fetch_done_pulse: done=%b ready=%b want 0 1", cmd_done, cmd_ready); end
    endtask

    task automatic test_alu_add();
        int lat, q; logic e, we, st; logic [15:0] ad, wd;
        setr(3'd1, 16'h7FFF);
        fetch(16'h0001);
        issue(3'd1, 3'd2, 3'd1, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 16'h0, 0, lat, e, ad, we, wd, st, q);
        rf_debug_addr = 3'd2; #1;
        n_cmp++; if (rf_debug_data !== 16'h8000) begin n_err++; $display("FAIL alu_add_r2: got %h want 8000", rf_debug_data); end
        n_cmp++; if (nzp !== 3'b100) begin n_err++; $display("FAIL alu_add_nzp: got %b want 100", nzp); end
        n_cmp++; if (lat !== 0) begin n_err++; $display("FAIL alu_done_lat: got %0d want 0", lat); end
    endtask

    task automatic test_branch();
        int lat, q; logic e, we, st; logic [15:0] ad, wd;
        setpc(16'h0004);
        fetch(16'h05FE);
        setr(3'd5, 16'h0000);
        n_cmp++; if (nzp !== 3'b010 || pc_debug_data !== 16'h0005) begin n_err++; $display("FAIL br_setup: nzp=%b pc=%h want 010 0005", nzp, pc_debug_data); end
        issue(3'd4, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0, 0, lat, e, ad, we, wd, st, q);
        n_cmp++; if (pc_debug_data !== 16'h0003) begin n_err++; $display("FAIL br_taken_pc: got %h want 0003", pc_debug_data); end
        setpc(16'h0004);
        fetch(16'h05FE);
        setr(3'd5, 16'h8000);
        issue(3'd4, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0, 0, lat, e, ad, we, wd, st, q);
        n_cmp++; if (pc_debug_data !== 16'h0005) begin n_err++; $display("FAIL br_not_taken_pc: got %h want 0005", pc_debug_data); end
    endtask

    task automatic test_jump_link();
        int lat, q; logic e, we, st; logic [15:0] ad, wd;
        setr(3'd7, 16'h0040);
        setpc(16'h0010);
        issue(3'd5, 3'd0, 3'd7, 3'd0, 2'd0, 1'b0, 1'b1, 1'b1, 16'h0, 0, lat, e, ad, we, wd, st, q);
        rf_debug_addr = 3'd7; #1;
        n_cmp++; if (pc_debug_data !== 16'h0040) begin n_err++; $display("FAIL jmp_pc: got %h want 0040", pc_debug_data); end
        n_cmp++; if (rf_debug_data !== 16'h0010) begin n_err++; $display("FAIL jmp_r7: got %h want 0010", rf_debug_data); end
    endtask

    task automatic test_store_reset();
        int guard = 0;
        setr(3'd2, 16'hBEEF);
        setpc(16'h0020);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_sb = 3'd2; cmd_base = 1'b0;
        while (!cmd_ready && guard < 20) begin @(negedge clk); guard++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 16'hBEEF) begin n_err++; $display("FAIL st_held: req=%b we=%b wdata=%h want 1 1 beef", mem_req, mem_we, mem_wdata); end
        rst = 1'b0;
        #1;
        n_cmp++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin n_err++; $display("FAIL st_rst_req: req=%b we=%b want 0 0", mem_req, mem_we); end
        n_cmp++; if (pc_debug_data !== 16'h0000) begin n_err++; $display("FAIL st_rst_pc: got %h want 0000", pc_debug_data); end
        @(negedge clk);
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h5A5A;
        @(negedge clk);
        mem_ack = 1'b0;
        n_cmp++; if (cmd_done !== 1'b0 || mem_req !== 1'b0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL st_late_ack: done=%b req=%b ready=%b want 0 0 1", cmd_done, mem_req, cmd_ready); end
        n_cmp++; if (ir !== 16'h0 || nzp !== 3'b010 || pc_debug_data !== 16'h0) begin n_err++; $display("FAIL st_late_state: ir=%h nzp=%b pc=%h want 0000 010 0000", ir, nzp, pc_debug_data); end
        rf_debug_addr = 3'd2; #1;
        n_cmp++; if (rf_debug_data !== 16'h0) begin n_err++; $display("FAIL st_late_r2: got %h want 0000", rf_debug_data); end
    endtask

    task automatic test_random();
        int lat, req_n, waits;
        logic [2:0] op, rd, sa, sb; logic [1:0] fn; logic imm, base, link;
        logic [15:0] rdata, ad, wd, e_addr, e_wdata;
        logic e, we, st, e_mem, e_we, e_err;
        do_reset();
        model_reset();
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7)); rd = 3'($urandom); sa = 3'($urandom); sb = 3'($urandom);
            fn = 2'($urandom); imm = 1'($urandom); base = 1'($urandom); link = 1'($urandom);
            rdata = 16'($urandom); waits = $urandom_range(0, 3);
            model_step(op, rd, sa, sb, fn, imm, base, link, rdata, e_mem, e_addr, e_we, e_wdata, e_err);
            issue(op, rd, sa, sb, fn, imm, base, link, rdata, waits, lat, e, ad, we, wd, st, req_n);
            n_cmp++; if (lat !== (e_mem ? waits + 1 : 0)) begin n_err++; $display("FAIL rand_lat[%0d] op%0d: got %0d want %0d", i, op, lat, e_mem ? waits + 1 : 0); end
            n_cmp++; if (e !== e_err) begin n_err++; $display("FAIL rand_err[%0d] op%0d: got %b want %b", i, op, e, e_err); end
            if (e_mem) begin
                n_cmp++; if (ad !== e_addr || we !== e_we) begin n_err++; $display("FAIL rand_addr[%0d] op%0d: got %h we=%b want %h we=%b", i, op, ad, we, e_addr, e_we); end
                n_cmp++; if (st !== 1'b1 || req_n !== waits + 1) begin n_err++; $display("FAIL rand_req[%0d]: stable=%b cycles=%0d want 1 %0d", i, st, req_n, waits + 1); end
                if (e_we) begin
                    n_cmp++; if (wd !== e_wdata) begin n_err++; $display("FAIL rand_wdata[%0d]: got %h want %h", i, wd, e_wdata); end
                end
            end
            n_cmp++; if (pc_debug_data !== m_pc) begin n_err++; $display("FAIL rand_pc[%0d] op%0d: got %h want %h", i, op, pc_debug_data, m_pc); end
            n_cmp++; if (ir !== m_ir) begin n_err++; $display("FAIL rand_ir[%0d]: got %h want %h", i, ir, m_ir); end
            n_cmp++; if (nzp !== m_nzp) begin n_err++; $display("FAIL rand_nzp[%0d] op%0d: got %b want %b", i, op, nzp, m_nzp); end
            for (int r = 0; r < 8; r++) begin
                rf_debug_addr = 3'(r); #1;
                n_cmp++; if (rf_debug_data !== m_rf[r]) begin n_err++; $display("FAIL rand_rf%0d[%0d] op%0d: got %h want %h", r, i, op, rf_debug_data, m_rf[r]); end
            end
        end
    endtask

    task automatic test_wide();
        int lat; logic e;
        do_reset();
        #1;
        n_cmp++; if (w_pc_debug_data !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL w_reset_pc: got %h want ffffffff", w_pc_debug_data); end
        w_issue(3'd0, 32'hCAFE_0123, lat, e);
        n_cmp++; if (w_pc_debug_data !== 32'h0) begin n_err++; $display("FAIL w_pc_wrap: got %h want 00000000", w_pc_debug_data); end
        n_cmp++; if (w_ir !== 32'hCAFE_0123 || lat !== 1) begin n_err++; $display("FAIL w_fetch: ir=%h lat=%0d want cafe0123 1", w_ir, lat); end
        w_issue(3'd7, 32'h0, lat, e);
        n_cmp++; if (e !== 1'b1 || w_cmd_done !== 1'b1 || lat !== 0) begin n_err++; $display("FAIL w_op7_pulse: err=%b done=%b lat=%0d want 1 1 0", e, w_cmd_done, lat); end
        n_cmp++; if (w_pc_debug_data !== 32'h0 || w_ir !== 32'hCAFE_0123 || w_nzp !== 3'b010) begin n_err++; $display("FAIL w_op7_state: pc=%h ir=%h nzp=%b want 00000000 cafe0123 010", w_pc_debug_data, w_ir, w_nzp); end
        w_rf_debug_addr = 4'd7; #1;
        n_cmp++; if (w_rf_debug_data !== 32'h0) begin n_err++; $display("FAIL w_op7_rf: got %h want 00000000", w_rf_debug_data); end
        @(negedge clk);
        n_cmp++; if (w_cmd_err !== 1'b0 || w_cmd_done !== 1'b0) begin n_err++; $display("FAIL w_op7_drop: err=%b done=%b want 0 0", w_cmd_err, w_cmd_done); end
    endtask

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_rd = 3'd0; cmd_sa = 3'd0; cmd_sb = 3'd0;
        cmd_fn = 2'd0; cmd_imm = 1'b0; cmd_base = 1'b0; cmd_link = 1'b0;
        mem_ack = 1'b0; mem_rdata = 16'h0; rf_debug_addr = 3'd0;
        w_cmd_valid = 1'b0; w_cmd_op = 3'd0; w_mem_ack = 1'b0; w_mem_rdata = 32'h0; w_rf_debug_addr = 4'd0;
        test_reset();
        test_fetch();
        test_alu_add();
        test_branch();
        test_jump_link();
        test_store_reset();
        test_random();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
